edge_detector_multi: RTL and testbench

EDGE_DETECTOR_MULTI -- requirements
Module: edge_detector_multi

---
 rtl/edge_detector_multi_if.sv | 26 ++
 rtl/edge_detector_multi.sv | 172 +++++++++++++++++
 tb/tb_edge_detector_multi.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/edge_detector_multi_if.sv
// Bus bundle for edge_detector_multi: sample input side and edge result side.
interface edge_detector_multi_if #(
  parameter int LANES = 5,
  parameter int CW    = 8,
  parameter int DW    = 2*CW+4
);
  logic                  in_valid_i;
  logic [LANES*CW-1:0]   in_red_i;
  logic [LANES*CW-1:0]   in_green_i;
  logic [LANES*CW-1:0]   in_blue_i;
  logic [DW-1:0]         threshold_i;
  logic                  out_valid_o;
  logic [LANES-1:0]      edge_o;
  logic [LANES*DW-1:0]   dist_o;
  logic [15:0]           edge_count_o;

  modport master (
    output in_valid_i, in_red_i, in_green_i, in_blue_i, threshold_i,
    input  out_valid_o, edge_o, dist_o, edge_count_o
  );

  modport slave (
    input  in_valid_i, in_red_i, in_green_i, in_blue_i, threshold_i,
    output out_valid_o, edge_o, dist_o, edge_count_o
  );
endinterface

// File: rtl/edge_detector_multi.sv
// Multi-lane colour edge detector: moving average, gapped difference,
// squared distance and thresholding in a 4-stage pipeline.
module edge_detector_multi #(
  parameter int LANES    = 5,
  parameter int CW       = 8,
  parameter int AVG_LOG2 = 2,
  parameter int GAP      = 4
) (
  input logic clock,
  input logic reset,
  edge_detector_multi_if.slave bus
);
  localparam int N    = 1 << AVG_LOG2;
  localparam int DW   = 2*CW+4;
  localparam int WARM = N + GAP;
  localparam int SW   = CW + AVG_LOG2;
  localparam int SQW  = 2*CW;
  localparam int FW   = (WARM > 1) ? $clog2(WARM) : 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(WARM-1);

  typedef logic [LANES-1:0][2:0][CW-1:0] pix_t;

  pix_t pix_in;

  always_comb begin
    pix_in = '0;
    for (int l = 0; l < LANES; l++) begin
      pix_in[l][0] = bus.in_red_i[l*CW +: CW];
      pix_in[l][1] = bus.in_green_i[l*CW +: CW];
      pix_in[l][2] = bus.in_blue_i[l*CW +: CW];
    end
  end

  // window update
  pix_t [N-1:0]                  win_q, win_d;
  logic [LANES-1:0][2:0][SW-1:0] sum_q, sum_d;
  logic [FW-1:0]                 fill_q, fill_d;
  logic                          v1_q, ov1_q;

  always_comb begin
    win_d  = win_q;
    sum_d  = sum_q;
    fill_d = fill_q;
    if (bus.in_valid_i) begin
      win_d[0] = pix_in;
      for (int i = 1; i < N; i++) win_d[i] = win_q[i-1];
      for (int l = 0; l < LANES; l++)
        for (int c = 0; c < 3; c++)
          sum_d[l][c] = sum_q[l][c] + SW'(pix_in[l][c])
                      - SW'(win_q[N-1][l][c]);
      if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      win_q  <= '0;
      sum_q  <= '0;
      fill_q <= '0;
      v1_q   <= 1'b0;
      ov1_q  <= 1'b0;
    end else begin
      win_q  <= win_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
      v1_q   <= bus.in_valid_i;
      ov1_q  <= bus.in_valid_i && (fill_q == FILL_MAX);
    end
  end

  // average / delay line
  pix_t           avg;
  pix_t [GAP-1:0] dly_q, dly_d;
  pix_t           cur_q, old_q;
  logic           ov2_q;

  always_comb begin
    avg = '0;
    for (int l = 0; l < LANES; l++)
      for (int c = 0; c < 3; c++)
        avg[l][c] = sum_q[l][c][SW-1:AVG_LOG2];
    dly_d = dly_q;
    if (v1_q) begin
      dly_d[0] = avg;
      for (int i = 1; i < GAP; i++) dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dly_q <= '0;
      cur_q <= '0;
      old_q <= '0;
      ov2_q <= 1'b0;
    end else begin
      dly_q <= dly_d;
      ov2_q <= ov1_q;
      if (v1_q) begin
        cur_q <= avg;
        old_q <= dly_q[GAP-1];
      end
    end
  end

  // difference / square
  logic [LANES-1:0][DW-1:0] dist3_d, dist3_q;
  logic                     ov3_q;

  always_comb begin
    logic [CW-1:0]  mag;
    logic [SQW-1:0] sq;
    mag     = '0;
    sq      = '0;
    dist3_d = '0;
    for (int l = 0; l < LANES; l++)
      for (int c = 0; c < 3; c++) begin
        mag = (cur_q[l][c] >= old_q[l][c]) ?
              cur_q[l][c] - old_q[l][c] :
              old_q[l][c] - cur_q[l][c];
        sq  = SQW'(mag) * SQW'(mag);
        dist3_d[l] = dist3_d[l] + DW'(sq);
      end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dist3_q <= '0;
      ov3_q   <= 1'b0;
    end else begin
      ov3_q <= ov2_q;
      if (ov2_q) dist3_q <= dist3_d;
    end
  end

  // compare / count
  logic [LANES-1:0]         edge_d, edge_q;
  logic [LANES-1:0][DW-1:0] dist_q;
  logic [15:0]              cnt_q, cnt_d;
  logic [16:0]              cnt_sum;
  logic                     ov4_q;

  always_comb begin
    edge_d  = '0;
    cnt_sum = {1'b0, cnt_q};
    for (int l = 0; l < LANES; l++) begin
      edge_d[l] = dist3_q[l] > bus.threshold_i;
      cnt_sum   = cnt_sum + 17'(edge_d[l]);
    end
    cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      edge_q <= '0;
      dist_q <= '0;
      cnt_q  <= '0;
      ov4_q  <= 1'b0;
    end else begin
      ov4_q <= ov3_q;
      if (ov3_q) begin
        edge_q <= edge_d;
        dist_q <= dist3_q;
        cnt_q  <= cnt_d;
      end
    end
  end

  assign bus.out_valid_o  = ov4_q;
  assign bus.edge_o       = edge_q;
  assign bus.dist_o       = dist_q;
  assign bus.edge_count_o = cnt_q;
endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed bench for edge_detector_multi with hand-computed expectations.
module tb_edge_detector_multi;
  localparam int LANES = 5;
  localparam int CW    = 8;
  localparam int DW    = 20;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  edge_detector_multi_if #(.LANES(LANES), .CW(CW), .DW(DW)) bus();

  edge_detector_multi #(
    .LANES(LANES), .CW(CW), .AVG_LOG2(2), .GAP(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int exp_tab [20];
  logic [LANES*DW-1:0] last_dist;
  logic [LANES-1:0]    last_edge;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input int val, input bit all_lanes);
    bus.in_valid_i = v;
    bus.in_red_i   = '0;
    bus.in_green_i = '0;
    bus.in_blue_i  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (all_lanes) begin
        bus.in_red_i[l*CW +: CW]   = CW'(val);
        bus.in_green_i[l*CW +: CW] = CW'(val);
        bus.in_blue_i[l*CW +: CW]  = CW'(val);
      end else if (l == 2) begin
        bus.in_red_i[l*CW +: CW] = CW'(val);
      end
    end
  endtask

  // reset pulse with a live sample on the bus, which must be discarded
  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    drive(1'b1, 200, 1'b1);
    @(posedge clock); #1;
    reset = 1'b0;
    drive(1'b0, 0, 1'b1);
    @(negedge clock);
    chk("rst_ov",   bus.out_valid_o, 0);
    chk("rst_edge", bus.edge_o, 0);
    chk("rst_dist", bus.dist_o, 0);
    chk("rst_cnt",  bus.edge_count_o, 0);
    last_dist = '0;
    last_edge = '0;
  endtask

  task automatic run(input int nsamp, input int kstep, input int base,
                     input int hi, input bit all_lanes, input bit toggle,
                     input int thr, input int exp_cnt);
    int iters;
    int s;
    int k;
    bit ov_exp;
    logic [LANES*DW-1:0] ed;
    logic [LANES-1:0]    ee;
    iters = (toggle ? 2*nsamp : nsamp) + 4;
    bus.threshold_i = DW'(thr);
    for (int c = 0; c < iters; c++) begin
      @(posedge clock); #1;
      if (toggle) begin
        if (c % 2 == 0 && c/2 < nsamp)
          drive(1'b1, (c/2 >= kstep) ? hi : base, all_lanes);
        else
          drive(1'b0, 0, all_lanes);
      end else begin
        if (c < nsamp)
          drive(1'b1, (c >= kstep) ? hi : base, all_lanes);
        else
          drive(1'b0, 0, all_lanes);
      end
      @(negedge clock);
      s = c - 4;
      ov_exp = 1'b0;
      k = 0;
      if (s >= 0) begin
        if (toggle) begin
          if (s % 2 == 0 && s/2 < nsamp) begin
            k = s/2;
            ov_exp = (k >= 7);
          end
        end else if (s < nsamp) begin
          k = s;
          ov_exp = (k >= 7);
        end
      end
      if (ov_exp) begin
        ed = '0;
        ee = '0;
        for (int l = 0; l < LANES; l++) begin
          if (all_lanes || l == 2) begin
            ed[l*DW +: DW] = DW'(exp_tab[k]);
            ee[l] = (exp_tab[k] > thr);
          end
        end
        chk("ov_on", bus.out_valid_o, 1);
        chk("dist",  bus.dist_o, ed);
        chk("edge",  bus.edge_o, ee);
        last_dist = ed;
        last_edge = ee;
      end else begin
        chk("ov_off",    bus.out_valid_o, 0);
        chk("dist_hold", bus.dist_o, last_dist);
        chk("edge_hold", bus.edge_o, last_edge);
      end
    end
    chk("count", bus.edge_count_o, exp_cnt);
  endtask

  int  n_after;
  bit  wrapped;
  logic [15:0] prev_cnt;

  initial begin
    reset = 1'b1;
    bus.threshold_i = DW'(100);
    drive(1'b0, 0, 1'b1);
    repeat (2) @(posedge clock);
    do_reset();

    // constant colour: no edges
    for (int i = 0; i < 20; i++) exp_tab[i] = 0;
    run(20, 0, 50, 50, 1'b1, 1'b0, 100, 0);

    // lane 2 red step 0 -> 40 at sample 10
    do_reset();
    for (int i = 0; i < 20; i++) exp_tab[i] = 0;
    exp_tab[10] = 100;  exp_tab[11] = 400;
    exp_tab[12] = 900;  exp_tab[13] = 1600;
    exp_tab[14] = 900;  exp_tab[15] = 400;
    exp_tab[16] = 100;  exp_tab[17] = 0;
    run(18, 10, 0, 40, 1'b0, 1'b0, 100, 5);

    // same step with bubbles between samples
    do_reset();
    run(18, 10, 0, 40, 1'b0, 1'b1, 100, 5);

    // reset mid-stream: in-flight samples must vanish
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      drive(1'b1, (i >= 10) ? 40 : 0, 1'b0);
    end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("flush_ov", bus.out_valid_o, 0);
    end
    for (int i = 0; i < 20; i++) exp_tab[i] = 0;
    run(8, 0, 0, 0, 1'b0, 1'b0, 100, 0);

    // full-scale step on all lanes at the threshold boundary
    do_reset();
    for (int i = 0; i < 20; i++) exp_tab[i] = 0;
    exp_tab[10] = 11907;  exp_tab[11] = 48387;
    exp_tab[12] = 109443; exp_tab[13] = 195075;
    exp_tab[14] = 110592; exp_tab[15] = 49152;
    exp_tab[16] = 12288;
    run(18, 10, 0, 255, 1'b1, 1'b0, 195075, 0);
    do_reset();
    run(18, 10, 0, 255, 1'b1, 1'b0, 195074, 5);

    // square wave with zero threshold drives the counter into saturation
    do_reset();
    bus.threshold_i = '0;
    n_after  = -1;
    wrapped  = 1'b0;
    prev_cnt = '0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clock); #1;
      drive(1'b1, (i % 8 < 4) ? 255 : 0, 1'b1);
      @(negedge clock);
      if (bus.edge_count_o < prev_cnt) wrapped = 1'b1;
      prev_cnt = bus.edge_count_o;
      if (n_after >= 0) n_after++;
      else if (bus.edge_count_o == 16'hFFFF) n_after = 0;
      if (n_after == 200) break;
    end
    drive(1'b0, 0, 1'b1);
    chk("sat_reached", (n_after == 200), 1);
    chk("sat_hold",    bus.edge_count_o, 16'hFFFF);
    chk("no_wrap",     wrapped, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
